// File: rtl/sfu_pkg.sv
// Shared types and helpers for the SFU accumulate/drain row.
// Holds the FSM state enum, mode encoding and the drain saturate/ReLU function.
package sfu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Caller sign-extends the acc_bw value to 64 bits; result fits in obw bits.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int unsigned        obw,
                                                  input logic               relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (obw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (relu && (v < 0)) return '0;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sfu_acc_lane.sv
// One lane of the SFU row: entry array with read-modify-write accumulate and
// the registered saturating drain output.
module sfu_acc_lane
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24,
  parameter int out_bw  = 16,
  parameter int mij_len = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic                       first,
  input  logic [$clog2(mij_len)-1:0] wr_addr,
  input  logic signed [psum_bw-1:0]  din,
  input  logic [$clog2(mij_len)-1:0] rd_addr,
  input  logic                       rd_written,
  input  logic                       relu,
  input  logic                       load,
  output logic [out_bw-1:0]          dout
);

  logic signed [acc_bw-1:0] mem [mij_len];
  logic signed [acc_bw-1:0] din_ext;
  logic signed [acc_bw-1:0] cur;
  logic signed [acc_bw-1:0] nxt;
  logic signed [63:0]       rd_ext;
  logic signed [63:0]       sat;
  logic [out_bw-1:0]        dout_d;

  assign din_ext = acc_bw'(din);
  // Combinational read + registered write makes back-to-back hits to one entry
  // accumulate without an explicit bypass path.
  assign cur     = mem[wr_addr];
  assign nxt     = first ? din_ext : cur + din_ext;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= nxt;
  end

  always_comb begin
    rd_ext = 64'(mem[rd_addr]);
    sat    = sat_relu(rd_ext, out_bw, relu);
    dout_d = rd_written ? out_bw'(sat) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    dout <= '0;
    else if (load) dout <= dout_d;
  end

endmodule

// File: rtl/sfu_acc_row.sv
// SFU accumulate row: per-column psum accumulation (WS over kij_len passes,
// OS single pass) followed by a valid/ready drain with ReLU and saturation.
module sfu_acc_row
  import sfu_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24,
  parameter int out_bw  = 16,
  parameter int mij_len = 16,
  parameter int kij_len = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       relu_en,
  input  logic                       i_valid,
  input  logic                       i_last,
  input  logic [$clog2(mij_len)-1:0] i_addr,
  input  logic [col*psum_bw-1:0]     in,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [$clog2(mij_len)-1:0] o_addr,
  output logic [col*out_bw-1:0]      out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW = $clog2(mij_len);
  localparam int CW = $clog2(kij_len + 1);

  state_t            state, state_nxt;
  logic              mode_q, relu_q;
  logic [CW-1:0]     pass_cnt;
  logic [mij_len-1:0] bitmap;
  logic [AW-1:0]     rd_ptr;

  logic addr_ok, beat, pass_end, last_pass, accept, drain_end;
  logic start_job, acc_we, load_beat, err_set;

  generate
    if ((2 ** AW) == mij_len) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_npow2
      assign addr_ok = ({1'b0, i_addr} < (AW + 1)'(mij_len));
    end
  endgenerate

  assign beat      = i_valid && (state == ACCUM);
  assign pass_end  = beat && i_last;
  assign last_pass = (mode_q == MODE_OS) || (pass_cnt == CW'(kij_len - 1));
  assign accept    = o_valid && o_ready;
  assign drain_end = accept && (o_addr == AW'(mij_len - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (pass_end && last_pass) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    start_job = (state == IDLE) && start;
    acc_we    = beat && addr_ok;
    load_beat = (state == DRAIN) && (!o_valid || (accept && !drain_end));
    err_set   = i_valid && ((state == IDLE) || (state == DRAIN) ||
                            ((state == ACCUM) && !addr_ok));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE_WS;
      relu_q   <= 1'b0;
      pass_cnt <= '0;
      bitmap   <= '0;
      rd_ptr   <= '0;
      o_valid  <= 1'b0;
      o_addr   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= drain_end;
      if (start_job) begin
        mode_q   <= mode;
        relu_q   <= relu_en;
        pass_cnt <= '0;
        bitmap   <= '0;
        rd_ptr   <= '0;
        err      <= err_set;
      end else if (err_set) begin
        err <= 1'b1;
      end
      if (pass_end) pass_cnt <= pass_cnt + 1'b1;
      if (acc_we)   bitmap[i_addr] <= 1'b1;
      if (load_beat) begin
        o_valid <= 1'b1;
        o_addr  <= rd_ptr;
        rd_ptr  <= rd_ptr + 1'b1;
      end else if (drain_end) begin
        o_valid <= 1'b0;
      end
    end
  end

  generate
    for (genvar j = 0; j < col; j++) begin : g_lane
      sfu_acc_lane #(
        .psum_bw (psum_bw),
        .acc_bw  (acc_bw),
        .out_bw  (out_bw),
        .mij_len (mij_len)
      ) u_lane (
        .clk        (clk),
        .reset      (reset),
        .we         (acc_we),
        .first      (!bitmap[i_addr]),
        .wr_addr    (i_addr),
        .din        (in[j*psum_bw +: psum_bw]),
        .rd_addr    (rd_ptr),
        .rd_written (bitmap[rd_ptr]),
        .relu       (relu_q),
        .load       (load_beat),
        .dout       (out[j*out_bw +: out_bw])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sfu_acc_row.sv
// Self-checking bench for sfu_acc_row: directed table, backpressure, error
// and reset corner cases, plus randomized jobs against an arithmetic model.
module tb_sfu_acc_row;

  logic         clk = 1'b0;
  logic         reset, start, mode, relu_en, i_valid, i_last, o_ready;
  logic [3:0]   i_addr, o_addr;
  logic [127:0] in, out;
  logic         o_valid, busy, done, err;

  sfu_acc_row #(
    .col(8), .psum_bw(16), .acc_bw(24), .out_bw(16), .mij_len(16), .kij_len(9)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .relu_en(relu_en),
    .i_valid(i_valid), .i_last(i_last), .i_addr(i_addr), .in(in),
    .o_valid(o_valid), .o_ready(o_ready), .o_addr(o_addr), .out(out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] data;
    bit           last;
  } beat_t;

  typedef struct {
    bit          m;
    bit          r;
    logic [15:0] v0, v1;
    logic [3:0]  a;
    logic [15:0] e0, e1;
  } vec_t;

  beat_t        beats[$];
  logic [127:0] exp_q [16];
  logic [127:0] got_q [16];
  vec_t         tbl [6];
  int           vectors = 0;
  int           fails   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Reference: signed accumulation wrapping at 24 bits, first write replaces,
  // drain applies ReLU then clamps to 16-bit signed range.
  function automatic void build_model(input bit relu);
    longint acc [16][8];
    bit     wr  [16];
    for (int e = 0; e < 16; e++) wr[e] = 1'b0;
    foreach (beats[b]) begin
      for (int l = 0; l < 8; l++) begin
        logic signed [15:0] t;
        logic signed [23:0] w;
        longint s;
        t = beats[b].data[l*16 +: 16];
        s = wr[beats[b].addr] ? acc[beats[b].addr][l] + longint'(t) : longint'(t);
        w = s[23:0];
        acc[beats[b].addr][l] = longint'(w);
      end
      wr[beats[b].addr] = 1'b1;
    end
    for (int e = 0; e < 16; e++) begin
      exp_q[e] = '0;
      for (int l = 0; l < 8; l++) begin
        longint r;
        if (!wr[e])                      r = 0;
        else if (relu && acc[e][l] < 0)  r = 0;
        else if (acc[e][l] > 32767)      r = 32767;
        else if (acc[e][l] < -32768)     r = -32768;
        else                             r = acc[e][l];
        exp_q[e][l*16 +: 16] = r[15:0];
      end
    end
  endfunction

  task automatic start_job(input bit m, input bit r);
    start = 1'b1; mode = m; relu_en = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input bit gaps);
    foreach (beats[b]) begin
      if (gaps && ($urandom % 4 == 0)) begin
        i_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_valid = 1'b1; i_addr = beats[b].addr; in = beats[b].data; i_last = beats[b].last;
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  // rmode: 0 ready high, 1 random ready, 2 three-cycle stall at beat 4
  task automatic drain(input int rmode, input bit inj_err);
    int           got = 0;
    int           cyc = 0;
    int           stall_left = 0;
    bit           stall_started = 1'b0;
    bit           prev_stall = 1'b0;
    logic [3:0]   pa;
    logic [127:0] pd;
    while (got < 16 && cyc < 400) begin
      case (rmode)
        0: o_ready = 1'b1;
        1: o_ready = 1'($urandom % 2);
        default: begin
          if (!stall_started && o_valid && o_addr == 4'd4) begin
            stall_started = 1'b1;
            stall_left = 3;
          end
          o_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      if (inj_err) begin
        i_valid = 1'($urandom % 2);
        i_addr  = 4'($urandom);
        in      = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (o_valid) begin
        if (prev_stall) begin
          chk("hold_addr", 128'(o_addr), 128'(pa));
          chk("hold_data", out, pd);
        end
        if (o_ready) begin
          chk("beat_addr", 128'(o_addr), 128'(got));
          chk("beat_data", out, exp_q[got]);
          got_q[got] = out;
          got++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          pa = o_addr;
          pd = out;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("drain_count", 128'(got), 128'd16);
    chk("done_pulse", {126'd0, done, o_valid}, 128'b10);
    @(posedge clk); #1;
    chk("done_clear", {126'd0, done, busy}, 128'b00);
  endtask

  task automatic make_random(input int passes);
    logic [3:0] a;
    beats.delete();
    a = 4'($urandom);
    for (int p = 0; p < passes; p++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom % 3 != 0) a = 4'($urandom);
        beats.push_back('{addr: a, data: {$urandom, $urandom, $urandom, $urandom},
                          last: (i == n - 1)});
      end
    end
  endtask

  task automatic random_job(input int rmode, input bit inj_err);
    bit m, r;
    m = 1'($urandom);
    r = 1'($urandom);
    make_random(m ? 1 : 9);
    build_model(r);
    start_job(m, r);
    send_beats(1'b1);
    drain(rmode, inj_err);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'hFFFB, 16'h0007, 4'd2,  16'h0000, 16'h0007};
    tbl[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h8000, 4'd5,  16'h7FFF, 16'h8000};
    tbl[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0003, 4'd0,  16'h0000, 16'h001B};
    tbl[3] = '{1'b1, 1'b0, 16'hFFFB, 16'h8000, 4'd15, 16'hFFFB, 16'h8000};
    tbl[4] = '{1'b0, 1'b0, 16'h0E39, 16'hF1C7, 4'd7,  16'h7FFF, 16'h8000};
    tbl[5] = '{1'b0, 1'b0, 16'h0E38, 16'hF1C8, 4'd9,  16'h7FF8, 16'h8008};

    reset = 1'b0; start = 1'b0; mode = 1'b0; relu_en = 1'b0;
    i_valid = 1'b0; i_last = 1'b0; i_addr = '0; in = '0; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", out, '0);
    chk("reset_ctl", {121'd0, o_valid, o_addr, busy, done, err}, '0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // i_valid while IDLE flags err; the next start clears it
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("idle_err", 128'(err), 128'd1);

    // WS: 9 passes over all 16 entries, every lane +1
    beats.delete();
    for (int p = 0; p < 9; p++)
      for (int a = 0; a < 16; a++)
        beats.push_back('{addr: 4'(a), data: {8{16'h0001}}, last: (a == 15)});
    build_model(1'b0);
    start_job(1'b0, 1'b0);
    chk("start_clr_err", 128'(err), 128'd0);
    chk("busy_accum", 128'(busy), 128'd1);
    send_beats(1'b0);
    drain(0, 1'b0);
    for (int e = 0; e < 16; e += 5) chk("ws_ones", got_q[e], {8{16'd9}});

    foreach (tbl[t]) begin
      logic [127:0] d;
      d = '0;
      d[15:0]  = tbl[t].v0;
      d[31:16] = tbl[t].v1;
      beats.delete();
      for (int p = 0; p < (tbl[t].m ? 1 : 9); p++)
        beats.push_back('{addr: tbl[t].a, data: d, last: 1'b1});
      build_model(tbl[t].r);
      start_job(tbl[t].m, tbl[t].r);
      send_beats(1'b0);
      drain(0, 1'b0);
      chk("tbl_lane0", 128'(got_q[tbl[t].a][15:0]), 128'(tbl[t].e0));
      chk("tbl_lane1", 128'(got_q[tbl[t].a][31:16]), 128'(tbl[t].e1));
      chk("tbl_unwritten", got_q[4'(tbl[t].a + 4'd1)], '0);
    end

    random_job(2, 1'b0);

    random_job(1, 1'b1);
    chk("drain_err", 128'(err), 128'd1);
    random_job(0, 1'b0);
    chk("err_cleared", 128'(err), 128'd0);

    for (int k = 0; k < 6; k++) random_job(int'($urandom % 2), 1'b0);

    // Abort mid-ACCUM after 3 WS passes
    make_random(3);
    start_job(1'b0, 1'b0);
    send_beats(1'b0);
    chk("busy_pre_abort", 128'(busy), 128'd1);
    #3 reset = 1'b0;
    #1;
    chk("abort_ctl", {124'd0, busy, o_valid, err, done}, '0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    beats.delete();
    for (int p = 0; p < 9; p++)
      for (int a = 0; a < 16; a++)
        beats.push_back('{addr: 4'(a), data: {$urandom, $urandom, $urandom, $urandom},
                          last: (a == 15)});
    build_model(1'b0);
    start_job(1'b0, 1'b0);
    send_beats(1'b1);
    drain(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
